// File: rtl/lcd_row_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_row_scheduler
//
// Purpose:
//   Frame sequencer sitting between the two LCD row-character generators and
//   the LCD byte writer. A refresh request walks both rows of the display:
//   for each row a DDRAM set-address command is offered, then every column
//   index is presented to the generators, the registered character is
//   captured and offered to the LCD writer over a valid/ready handshake.
//   This block is the only owner of the column index and row select, so the
//   generators and the writer carry no counters of their own.
//
//   Frame order: addr0, row0 col0..COLS-1, addr1, row1 col0..COLS-1.
//   Refresh requests arriving while a frame is in progress collapse into a
//   single pending redraw that starts immediately after the current frame.
//
// Parameters:
//   COLS       characters per row, 1..16
//   ROW0_ADDR  DDRAM address of row 0, column 0
//   ROW1_ADDR  DDRAM address of row 1, column 0
//
// Ports:
//   i_clk        system clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_refresh    single-cycle redraw request
//   o_busy       high whenever the sequencer is not idle
//   o_charIndex  column index presented to the row generators
//   o_rowSel     row being fetched; selects the generator upstream
//   i_character  selected generator output, one cycle after o_charIndex
//   o_lcdValid   byte on o_lcdData is offered
//   o_lcdIsCmd   1 = command byte, 0 = character data
//   o_lcdData    command or character byte
//   i_lcdReady   writer accepts the byte when high together with o_lcdValid
//   o_frameDone  one-cycle pulse after the last byte of a frame is accepted
// -----------------------------------------------------------------------------
module lcd_row_scheduler #(
    parameter int          COLS      = 16,
    parameter logic [7:0]  ROW0_ADDR = 8'h00,
    parameter logic [7:0]  ROW1_ADDR = 8'h40
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_refresh,
    output logic       o_busy,
    output logic [3:0] o_charIndex,
    output logic       o_rowSel,
    input  logic [7:0] i_character,
    output logic       o_lcdValid,
    output logic       o_lcdIsCmd,
    output logic [7:0] o_lcdData,
    input  logic       i_lcdReady,
    output logic       o_frameDone
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // Last legal column; the index is never allowed to step past it.
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    // HD44780-style "set DDRAM address" commands for the two rows.
    localparam logic [7:0] CMD_ROW0 = 8'h80 | ROW0_ADDR;
    localparam logic [7:0] CMD_ROW1 = 8'h80 | ROW1_ADDR;

    // -------------------------------------------------------------------------
    // State encoding
    //   IDLE  : waiting for a refresh request
    //   ADDR  : set-address command offered, waiting for handshake
    //   FETCH : column index presented, generator registers its character
    //   WAIT  : generator output valid, captured at the end of this cycle
    //   SEND  : character offered, waiting for handshake
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t     state_q,      state_d;
    logic       pending_q,    pending_d;
    logic [3:0] char_index_q, char_index_d;
    logic       row_sel_q,    row_sel_d;
    logic [7:0] lcd_data_q,   lcd_data_d;
    logic       lcd_is_cmd_q, lcd_is_cmd_d;
    logic       lcd_valid_q,  lcd_valid_d;
    logic       frame_done_q, frame_done_d;

    // A byte leaves this block only on a rising edge with both sides high.
    logic handshake;
    assign handshake = lcd_valid_q & i_lcdReady;

    // Last column of the current row.
    logic at_last_col;
    assign at_last_col = (char_index_q == LAST_COL);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // through the case statement leaves it unassigned (no latches).
        state_d      = state_q;
        pending_d    = pending_q;
        char_index_d = char_index_q;
        row_sel_d    = row_sel_q;
        lcd_data_d   = lcd_data_q;
        lcd_is_cmd_d = lcd_is_cmd_q;
        lcd_valid_d  = lcd_valid_q;
        frame_done_d = 1'b0;

        // Any request while a frame is running is remembered once; extra
        // requests during the same frame simply re-set the same flag.
        if ((state_q != ST_IDLE) && i_refresh) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_refresh) begin
                    state_d      = ST_ADDR;
                    row_sel_d    = 1'b0;
                    char_index_d = 4'd0;
                    lcd_data_d   = CMD_ROW0;
                    lcd_is_cmd_d = 1'b1;
                    lcd_valid_d  = 1'b1;
                end
            end

            ST_ADDR: begin
                // Outputs hold by default until the writer takes the command.
                if (handshake) begin
                    state_d      = ST_FETCH;
                    lcd_valid_d  = 1'b0;
                    char_index_d = 4'd0;
                end
            end

            ST_FETCH: begin
                // Index is stable; the generator registers at this edge.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Generator output now reflects the index presented in FETCH.
                state_d      = ST_SEND;
                lcd_data_d   = i_character;
                lcd_is_cmd_d = 1'b0;
                lcd_valid_d  = 1'b1;
            end

            ST_SEND: begin
                if (handshake) begin
                    if (!at_last_col) begin
                        state_d      = ST_FETCH;
                        char_index_d = char_index_q + 4'd1;
                        lcd_valid_d  = 1'b0;
                    end else if (!row_sel_q) begin
                        // End of row 0: go straight to the row-1 address
                        // command; valid stays high across the switch.
                        state_d      = ST_ADDR;
                        row_sel_d    = 1'b1;
                        lcd_data_d   = CMD_ROW1;
                        lcd_is_cmd_d = 1'b1;
                    end else begin
                        // End of frame.
                        frame_done_d = 1'b1;
                        row_sel_d    = 1'b0;
                        char_index_d = 4'd0;
                        lcd_valid_d  = 1'b0;
                        // A request landing on this very edge counts as
                        // pending, so it restarts the frame without idling.
                        if (pending_q || i_refresh) begin
                            state_d      = ST_ADDR;
                            pending_d    = 1'b0;
                            lcd_data_d   = CMD_ROW0;
                            lcd_is_cmd_d = 1'b1;
                            lcd_valid_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                lcd_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values computed before this edge, independent of order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            char_index_q <= 4'd0;
            row_sel_q    <= 1'b0;
            lcd_data_q   <= 8'h00;
            lcd_is_cmd_q <= 1'b0;
            lcd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            char_index_q <= char_index_d;
            row_sel_q    <= row_sel_d;
            lcd_data_q   <= lcd_data_d;
            lcd_is_cmd_q <= lcd_is_cmd_d;
            lcd_valid_q  <= lcd_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Busy is decoded from the state register so it drops with reset at once.
    assign o_busy      = (state_q != ST_IDLE);
    assign o_charIndex = char_index_q;
    assign o_rowSel    = row_sel_q;
    assign o_lcdValid  = lcd_valid_q;
    assign o_lcdIsCmd  = lcd_is_cmd_q;
    assign o_lcdData   = lcd_data_q;
    assign o_frameDone = frame_done_q;

endmodule

// File: tb/tb_lcd_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_row_scheduler
//
// Two instances: A with the default 16-column geometry, B with a single
// column and row 1 at DDRAM address 8'h14. A registered character generator
// model sits upstream of each. Expected byte streams are computed from the
// frame layout (position in frame -> command or generator value).
// -----------------------------------------------------------------------------
module tb_lcd_row_scheduler;

    localparam int         COLS_A = 16;
    localparam logic [7:0] R0_A   = 8'h00;
    localparam logic [7:0] R1_A   = 8'h40;
    localparam int         COLS_B = 1;
    localparam logic [7:0] R0_B   = 8'h00;
    localparam logic [7:0] R1_B   = 8'h14;
    localparam int         FRAME_A = 2 + 2 * COLS_A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       refresh_a = 1'b0, ready_a = 1'b1;
    logic       busy_a, row_a, valid_a, cmd_a, done_a;
    logic [3:0] idx_a;
    logic [7:0] data_a, char_a = 8'h00;

    logic       refresh_b = 1'b0, ready_b = 1'b1;
    logic       busy_b, row_b, valid_b, cmd_b, done_b;
    logic [3:0] idx_b;
    logic [7:0] data_b, char_b = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] gen_base = 8'h41;
    bit         rand_ready = 1'b0;

    // Monitor state for instance A.
    logic [8:0]  acc_a[$];
    int          stall_changes = 0;
    int          done_cnt_a = 0;
    logic        stall_prev = 1'b0;
    logic [13:0] stall_snap = '0;

    lcd_row_scheduler #(.COLS(COLS_A), .ROW0_ADDR(R0_A), .ROW1_ADDR(R1_A)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh_a), .o_busy(busy_a),
        .o_charIndex(idx_a), .o_rowSel(row_a), .i_character(char_a),
        .o_lcdValid(valid_a), .o_lcdIsCmd(cmd_a), .o_lcdData(data_a),
        .i_lcdReady(ready_a), .o_frameDone(done_a)
    );

    lcd_row_scheduler #(.COLS(COLS_B), .ROW0_ADDR(R0_B), .ROW1_ADDR(R1_B)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh_b), .o_busy(busy_b),
        .o_charIndex(idx_b), .o_rowSel(row_b), .i_character(char_b),
        .o_lcdValid(valid_b), .o_lcdIsCmd(cmd_b), .o_lcdData(data_b),
        .i_lcdReady(ready_b), .o_frameDone(done_b)
    );

    always #5 clk = ~clk;

    // Character a generator returns for a given row and column.
    function automatic logic [7:0] gen_char(input logic row, input logic [3:0] idx);
        return gen_base + {4'h0, idx} + (row ? 8'h10 : 8'h00);
    endfunction

    // {is_cmd, byte} expected at position pos of a frame.
    function automatic logic [8:0] expected_byte(input int pos, input int cols,
                                                 input logic [7:0] r0, input logic [7:0] r1);
        if (pos == 0)        return {1'b1, 8'h80 | r0};
        if (pos <= cols)     return {1'b0, gen_char(1'b0, 4'(pos - 1))};
        if (pos == cols + 1) return {1'b1, 8'h80 | r1};
        return {1'b0, gen_char(1'b1, 4'(pos - cols - 2))};
    endfunction

    // Registered upstream generators: one cycle latency from index/row.
    always @(posedge clk) begin
        char_a <= gen_char(row_a, idx_a);
        char_b <= gen_char(row_b, idx_b);
    end

    // Ready driver for instance A, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        ready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Recorder for instance A: accepted bytes, stall stability, done pulses.
    always @(negedge clk) begin
        if (valid_a && ready_a) acc_a.push_back({cmd_a, data_a});
        if (stall_prev && (valid_a !== 1'b1 || {cmd_a, data_a, row_a, idx_a} !== stall_snap))
            stall_changes <= stall_changes + 1;
        stall_prev <= rst_n && valid_a && !ready_a;
        stall_snap <= {cmd_a, data_a, row_a, idx_a};
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        checks++; if (idx_a !== 4'd0)   begin errors++; $display("FAIL rst_idx: got %h want 0", idx_a); end
        checks++; if (row_a !== 1'b0)   begin errors++; $display("FAIL rst_row: got %b want 0", row_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_a); end
        checks++; if (cmd_a !== 1'b0)   begin errors++; $display("FAIL rst_cmd: got %b want 0", cmd_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", done_a); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({busy_a, valid_a, busy_b, valid_b} !== 4'b0)
            begin errors++; $display("FAIL rst_idle_after: got %b want 0000", {busy_a, valid_a, busy_b, valid_b}); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_frame();
        int done_at = 0;
        int pulses = 0;
        rand_ready = 1'b0;
        gen_base = 8'h41;
        @(posedge clk); #2;
        acc_a.delete();
        refresh_a = 1'b1;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL sf_pre_valid: got %b want 0", valid_a); end
        @(posedge clk); #2;
        refresh_a = 1'b0;
        @(negedge clk);   // cycle 1: first valid
        checks++; if ({busy_a, valid_a, cmd_a, row_a, data_a} !== {4'b1110, 8'h80})
            begin errors++; $display("FAIL sf_first_valid: got %b_%h want 1110_80", {busy_a, valid_a, cmd_a, row_a}, data_a); end
        for (int n = 2; n <= 130; n++) begin
            @(negedge clk);
            if (done_a) begin
                pulses++;
                if (done_at == 0) begin
                    done_at = n;
                    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sf_busy_at_done: got %b want 0", busy_a); end
                end
            end
        end
        checks++; if (done_at != 99) begin errors++; $display("FAIL sf_done_cycle: got %0d want 99", done_at); end
        checks++; if (pulses != 1)   begin errors++; $display("FAIL sf_done_pulses: got %0d want 1", pulses); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL sf_busy_end: got %b want 0", busy_a); end
        checks++; if (acc_a.size() != FRAME_A) begin errors++; $display("FAIL sf_count: got %0d want %0d", acc_a.size(), FRAME_A); end
        for (int i = 0; i < FRAME_A && i < acc_a.size(); i++) begin
            checks++;
            if (acc_a[i] !== expected_byte(i, COLS_A, R0_A, R1_A))
                begin errors++; $display("FAIL sf_byte[%0d]: got %h want %h", i, acc_a[i], expected_byte(i, COLS_A, R0_A, R1_A)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int sc0, d0;
        rand_ready = 1'b1;
        gen_base = 8'($urandom);
        @(posedge clk); #2;
        acc_a.delete();
        sc0 = stall_changes;
        d0 = done_cnt_a;
        refresh_a = 1'b1;
        @(posedge clk); #2;
        refresh_a = 1'b0;
        for (int c = 0; c < 3000 && done_cnt_a == d0; c++) @(posedge clk);
        checks++; if (done_cnt_a != d0 + 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt_a - d0); end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        checks++; if (stall_changes != sc0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_changes - sc0); end
        checks++; if (acc_a.size() != FRAME_A) begin errors++; $display("FAIL bp_count: got %0d want %0d", acc_a.size(), FRAME_A); end
        for (int i = 0; i < FRAME_A && i < acc_a.size(); i++) begin
            checks++;
            if (acc_a[i] !== expected_byte(i, COLS_A, R0_A, R1_A))
                begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, acc_a[i], expected_byte(i, COLS_A, R0_A, R1_A)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_multi_refresh();
        int pulses = 0;
        int gaps = 0;
        rand_ready = 1'b0;
        gen_base = 8'h30;
        @(posedge clk); #2;
        acc_a.delete();
        for (int n = 0; n <= 260; n++) begin
            @(negedge clk);
            if (done_a) begin
                pulses++;
                if (pulses == 1) begin
                    checks++;
                    if ({busy_a, valid_a, cmd_a, row_a, data_a} !== {4'b1110, 8'h80})
                        begin errors++; $display("FAIL mr_restart: got %b_%h want 1110_80", {busy_a, valid_a, cmd_a, row_a}, data_a); end
                end
            end
            if (n >= 2 && pulses < 2 && !busy_a) gaps++;
            refresh_a = (n == 0 || n == 10 || n == 40 || n == 70);
        end
        refresh_a = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL mr_pulses: got %0d want 2", pulses); end
        checks++; if (gaps != 0)   begin errors++; $display("FAIL mr_idle_gap: got %0d idle cycles want 0", gaps); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mr_busy_end: got %b want 0", busy_a); end
        checks++; if (acc_a.size() != 2 * FRAME_A) begin errors++; $display("FAIL mr_count: got %0d want %0d", acc_a.size(), 2 * FRAME_A); end
        for (int i = 0; i < 2 * FRAME_A && i < acc_a.size(); i++) begin
            checks++;
            if (acc_a[i] !== expected_byte(i % FRAME_A, COLS_A, R0_A, R1_A))
                begin errors++; $display("FAIL mr_byte[%0d]: got %h want %h", i, acc_a[i], expected_byte(i % FRAME_A, COLS_A, R0_A, R1_A)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_async_reset();
        bit found = 1'b0;
        int activity = 0;
        int d0;
        rand_ready = 1'b0;
        gen_base = 8'h50;
        @(negedge clk);
        refresh_a = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (row_a && idx_a == 4'd7 && valid_a && !cmd_a) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL ar_reach_row1_idx7: got not reached want reached"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy_a, idx_a, row_a, valid_a, cmd_a, data_a, done_a} !== 16'h0)
            begin errors++; $display("FAIL ar_outputs_zero: got %h want 0000", {busy_a, idx_a, row_a, valid_a, cmd_a, data_a, done_a}); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_a.delete();
        repeat (40) begin
            @(negedge clk);
            if (busy_a || valid_a || done_a) activity++;
        end
        checks++; if (activity != 0)   begin errors++; $display("FAIL ar_no_resume: got %0d active cycles want 0", activity); end
        checks++; if (acc_a.size() != 0) begin errors++; $display("FAIL ar_no_transfers: got %0d want 0", acc_a.size()); end
        // New frame after release runs from the beginning.
        gen_base = 8'($urandom);
        @(posedge clk); #2;
        acc_a.delete();
        d0 = done_cnt_a;
        refresh_a = 1'b1;
        @(posedge clk); #2;
        refresh_a = 1'b0;
        for (int c = 0; c < 400 && done_cnt_a == d0; c++) @(posedge clk);
        checks++; if (done_cnt_a != d0 + 1) begin errors++; $display("FAIL ar_new_frame_done: got %0d want 1", done_cnt_a - d0); end
        checks++; if (acc_a.size() != FRAME_A) begin errors++; $display("FAIL ar_count: got %0d want %0d", acc_a.size(), FRAME_A); end
        for (int i = 0; i < FRAME_A && i < acc_a.size(); i++) begin
            checks++;
            if (acc_a[i] !== expected_byte(i, COLS_A, R0_A, R1_A))
                begin errors++; $display("FAIL ar_byte[%0d]: got %h want %h", i, acc_a[i], expected_byte(i, COLS_A, R0_A, R1_A)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_cols1();
        logic [8:0] got[$];
        int done_at = 0;
        int pulses = 0;
        gen_base = 8'h61;
        @(negedge clk);
        refresh_b = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            refresh_b = 1'b0;
            if (valid_b && ready_b) got.push_back({cmd_b, data_b});
            if (done_b) begin pulses++; if (done_at == 0) done_at = n; end
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL c1_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expected_byte(i, COLS_B, R0_B, R1_B))
                begin errors++; $display("FAIL c1_byte[%0d]: got %h want %h", i, got[i], expected_byte(i, COLS_B, R0_B, R1_B)); end
        end
        checks++; if (done_at != 9) begin errors++; $display("FAIL c1_done_cycle: got %0d want 9", done_at); end
        checks++; if (pulses != 1)  begin errors++; $display("FAIL c1_done_pulses: got %0d want 1", pulses); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL c1_busy_end: got %b want 0", busy_b); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_refresh_on_last();
        bit found = 1'b0;
        int d1;
        rand_ready = 1'b0;
        gen_base = 8'h21;
        @(posedge clk); #2;
        acc_a.delete();
        @(negedge clk);
        refresh_a = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (row_a && idx_a == 4'(COLS_A - 1) && valid_a && !cmd_a) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rl_reach_last: got not reached want reached"); end
        refresh_a = 1'b1;
        @(negedge clk);
        refresh_a = 1'b0;
        checks++; if ({done_a, busy_a, valid_a, cmd_a, row_a, idx_a, data_a} !== {5'b11110, 4'd0, 8'h80})
            begin errors++; $display("FAIL rl_restart: got %b_%h_%h want 11110_0_80", {done_a, busy_a, valid_a, cmd_a, row_a}, idx_a, data_a); end
        repeat (2) @(posedge clk);
        d1 = done_cnt_a;
        for (int c = 0; c < 300 && done_cnt_a == d1; c++) @(posedge clk);
        checks++; if (done_cnt_a != d1 + 1) begin errors++; $display("FAIL rl_second_done: got %0d want 1", done_cnt_a - d1); end
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rl_pending_cleared: got busy %b want 0", busy_a); end
        checks++; if (acc_a.size() != 2 * FRAME_A) begin errors++; $display("FAIL rl_count: got %0d want %0d", acc_a.size(), 2 * FRAME_A); end
        for (int i = 0; i < 2 * FRAME_A && i < acc_a.size(); i++) begin
            checks++;
            if (acc_a[i] !== expected_byte(i % FRAME_A, COLS_A, R0_A, R1_A))
                begin errors++; $display("FAIL rl_byte[%0d]: got %h want %h", i, acc_a[i], expected_byte(i % FRAME_A, COLS_A, R0_A, R1_A)); end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_multi_refresh();
        test_async_reset();
        test_cols1();
        test_refresh_on_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
